multiplier_hilo: RTL

MULTIPLIER_HILO -- requirements
Module: multiplier_hilo

---
 rtl/multiplier_hilo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/multiplier_hilo.sv
// Iterative 32x32 unsigned shift-add multiplier with Hi/Lo result registers.
// One MULTU start runs 32 iterations (one per clock), then writes Hi/Lo and
// pulses done for a single cycle. MFHI/MFLO read the registers combinationally.
//
// Handshake: start is a one-cycle request qualified by Signal==MULTU. It is
// accepted only in IDLE or DONE (the accepting edge is E0); while busy=1 the
// block is not ready and any start is dropped. done=1 for exactly one cycle
// marks that Hi/Lo now hold the new product.
module multiplier_hilo #(
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    input  logic        start,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] prod_q, prod_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic [32:0] sum33;
    logic [63:0] prod_shift;

    // A start request counts only when it carries the MULTU function code.
    assign accept = start && (Signal == MULTU);

    // One iteration: conditionally add multiplicand into the upper half with the
    // carry kept, then shift {carry, product} right by one.
    assign sum33      = {1'b0, prod_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
    assign prod_shift = {sum33, prod_q[31:1]};

    // State register and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next-state and datapath updates; Hi/Lo only change on the last iteration.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    mcand_d  = dataA;
                    mplier_d = dataB;
                    prod_d   = 64'd0;
                    cnt_d    = 5'd0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                prod_d   = prod_shift;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = prod_shift[63:32];
                    lo_d    = prod_shift[31:0];
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags, debug state and the Hi/Lo read mux.
    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_DONE);
        dbg_state_o = state_q;
        if (Signal == MFHI)
            dataOut = hi_q;
        else if (Signal == MFLO)
            dataOut = lo_q;
        else
            dataOut = 32'd0;
    end

endmodule
